// File: rtl/ram_arbiter2.sv
// Two-requester arbiter sharing one negedge-clocked 64x8 RAM.
// One access is accepted per cycle; read data returns to its requester one cycle later.
module ram_arbiter2 #(
  parameter int AW        = 6,
  parameter int DW        = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  logic          mem_rw_q,   mem_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q,  mem_din_d;
  logic          rr_last_q,  rr_last_d;
  logic          pend_rd_q,  pend_rd_d;
  logic          pend_id_q,  pend_id_d;
  logic          rvalid0_q,  rvalid0_d;
  logic          rvalid1_q,  rvalid1_d;
  logic [DW-1:0] rdata0_q,   rdata0_d;
  logic [DW-1:0] rdata1_q,   rdata1_d;

  logic          any_gnt_s;
  logic          sel_id_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  // Grant decision: ties go to the requester that did not win last, unless fixed priority.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (req0 && req1) begin
      if (PRIO_MODE != 0) begin
        gnt0 = 1'b1;
      end else if (rr_last_q) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // Mux the winning requester's command.
  always_comb begin
    any_gnt_s   = gnt0 | gnt1;
    sel_id_s    = 1'b0;
    sel_we_s    = 1'b0;
    sel_addr_s  = {AW{1'b0}};
    sel_wdata_s = {DW{1'b0}};
    if (gnt1) begin
      sel_id_s    = 1'b1;
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_id_s    = 1'b0;
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // Next-state: RAM command, arbitration history and read response routing.
  always_comb begin
    mem_rw_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rr_last_d  = rr_last_q;
    pend_rd_d  = 1'b0;
    pend_id_d  = pend_id_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    if (any_gnt_s) begin
      mem_rw_d   = sel_we_s;
      mem_addr_d = sel_addr_s;
      if (sel_we_s) begin
        mem_din_d = sel_wdata_s;
      end else begin
        mem_din_d = mem_din_q;
      end
      rr_last_d = sel_id_s;
      pend_rd_d = ~sel_we_s;
      pend_id_d = sel_id_s;
    end else begin
      // Idle: the RAM re-reads the held address and that result is ignored.
      mem_rw_d  = 1'b0;
      pend_rd_d = 1'b0;
    end

    if (pend_rd_q) begin
      if (pend_id_q) begin
        rvalid1_d = 1'b1;
        rdata1_d  = mem_dout;
      end else begin
        rvalid0_d = 1'b1;
        rdata0_d  = mem_dout;
      end
    end else begin
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
    end
  end

  // State registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rw_q   <= 1'b0;
      mem_addr_q <= {AW{1'b0}};
      mem_din_q  <= {DW{1'b0}};
      rr_last_q  <= 1'b1;
      pend_rd_q  <= 1'b0;
      pend_id_q  <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= {DW{1'b0}};
      rdata1_q   <= {DW{1'b0}};
    end else begin
      mem_rw_q   <= mem_rw_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rr_last_q  <= rr_last_d;
      pend_rd_q  <= pend_rd_d;
      pend_id_q  <= pend_id_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign mem_rw   = mem_rw_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter2.sv
// Bench for ram_arbiter2: round-robin instance plus a fixed-priority instance,
// each attached to a behavioural negedge RAM.
module tb_ram_arbiter2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       mem_rw;
  logic [5:0] mem_addr;
  logic [7:0] mem_din, mem_dout;

  logic       p_req0, p_we0, p_req1, p_we1;
  logic [5:0] p_addr0, p_addr1;
  logic [7:0] p_wdata0, p_wdata1;
  logic       p_gnt0, p_gnt1, p_rvalid0, p_rvalid1;
  logic [7:0] p_rdata0, p_rdata1;
  logic       p_mem_rw;
  logic [5:0] p_mem_addr;
  logic [7:0] p_mem_din, p_mem_dout;

  logic [7:0] ram0 [64];
  logic [7:0] ram1 [64];
  logic [7:0] mdl_mem [64];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter2 #(.AW(6), .DW(8), .PRIO_MODE(0)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  ram_arbiter2 #(.AW(6), .DW(8), .PRIO_MODE(1)) u_dut_prio (
    .clk(clk), .reset(reset),
    .req0(p_req0), .we0(p_we0), .addr0(p_addr0), .wdata0(p_wdata0),
    .gnt0(p_gnt0), .rvalid0(p_rvalid0), .rdata0(p_rdata0),
    .req1(p_req1), .we1(p_we1), .addr1(p_addr1), .wdata1(p_wdata1),
    .gnt1(p_gnt1), .rvalid1(p_rvalid1), .rdata1(p_rdata1),
    .mem_rw(p_mem_rw), .mem_addr(p_mem_addr), .mem_din(p_mem_din), .mem_dout(p_mem_dout)
  );

  function automatic logic [7:0] init_val(int i);
    return (i == 39) ? 8'hAA : 8'(i * 7 + 3);
  endfunction

  // Behavioural RAMs: execute on negedge, registered dout; preloaded while reset is low.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) ram0[i[5:0]] <= init_val(i);
      mem_dout <= 8'h00;
    end else if (mem_rw) begin
      ram0[mem_addr] <= mem_din;
    end else begin
      mem_dout <= ram0[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) ram1[i[5:0]] <= init_val(i);
      p_mem_dout <= 8'h00;
    end else if (p_mem_rw) begin
      ram1[p_mem_addr] <= p_mem_din;
    end else begin
      p_mem_dout <= ram1[p_mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic r0; logic w0; logic [5:0] a0; logic [7:0] d0;
    logic r1; logic w1; logic [5:0] a1; logic [7:0] d1;
    logic g0; logic g1; logic v0; logic v1; logic [7:0] q0; logic [7:0] q1;
  } vec_t;

  vec_t tbl [10];

  // Random-phase requester and reference model state
  logic       act [2];
  logic       rwe [2];
  logic [5:0] rad [2];
  logic [7:0] rwd [2];
  logic [7:0] exp_q [2];
  logic       mdl_last;
  logic       pend;
  logic       pid;
  logic [7:0] pdata;
  logic       eg [2];
  int         w;

  initial begin
    for (int i = 0; i < 64; i++) mdl_mem[i] = init_val(i);
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd35; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 6'd0;  wdata1 = 8'h00;
    p_req0 = 1'b0; p_we0 = 1'b0; p_addr0 = 6'd0; p_wdata0 = 8'h00;
    p_req1 = 1'b0; p_we1 = 1'b0; p_addr1 = 6'd0; p_wdata1 = 8'h00;

    // Reset held with a pending request
    @(negedge clk);
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;

    // Directed table: write/read, contention, read-after-write
    tbl[0] = '{1'b1,1'b1,6'd35,8'hFF, 1'b0,1'b0,6'd0,8'h00,  1'b1,1'b0,1'b0,1'b0,8'h00,8'h00};
    tbl[1] = '{1'b1,1'b0,6'd35,8'h00, 1'b0,1'b0,6'd0,8'h00,  1'b1,1'b0,1'b0,1'b0,8'h00,8'h00};
    tbl[2] = '{1'b0,1'b0,6'd0,8'h00,  1'b0,1'b0,6'd0,8'h00,  1'b0,1'b0,1'b1,1'b0,8'hFF,8'h00};
    tbl[3] = '{1'b1,1'b0,6'd35,8'h00, 1'b1,1'b0,6'd39,8'h00, 1'b0,1'b1,1'b0,1'b0,8'hFF,8'h00};
    tbl[4] = '{1'b1,1'b0,6'd35,8'h00, 1'b1,1'b0,6'd39,8'h00, 1'b1,1'b0,1'b0,1'b1,8'hFF,8'hAA};
    tbl[5] = '{1'b1,1'b0,6'd35,8'h00, 1'b1,1'b0,6'd39,8'h00, 1'b0,1'b1,1'b1,1'b0,8'hFF,8'hAA};
    tbl[6] = '{1'b1,1'b0,6'd35,8'h00, 1'b1,1'b1,6'd39,8'h5A, 1'b1,1'b0,1'b0,1'b1,8'hFF,8'hAA};
    tbl[7] = '{1'b0,1'b0,6'd0,8'h00,  1'b1,1'b1,6'd39,8'h5A, 1'b0,1'b1,1'b1,1'b0,8'hFF,8'hAA};
    tbl[8] = '{1'b1,1'b0,6'd39,8'h00, 1'b0,1'b0,6'd0,8'h00,  1'b1,1'b0,1'b0,1'b0,8'hFF,8'hAA};
    tbl[9] = '{1'b0,1'b0,6'd0,8'h00,  1'b0,1'b0,6'd0,8'h00,  1'b0,1'b0,1'b1,1'b0,8'h5A,8'hAA};

    mdl_last = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req0 = tbl[k].r0; we0 = tbl[k].w0; addr0 = tbl[k].a0; wdata0 = tbl[k].d0;
      req1 = tbl[k].r1; we1 = tbl[k].w1; addr1 = tbl[k].a1; wdata1 = tbl[k].d1;
      #1;
      chk($sformatf("tbl%0d_gnt0", k), 32'(gnt0), 32'(tbl[k].g0));
      chk($sformatf("tbl%0d_gnt1", k), 32'(gnt1), 32'(tbl[k].g1));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_rvalid0", k), 32'(rvalid0), 32'(tbl[k].v0));
      chk($sformatf("tbl%0d_rvalid1", k), 32'(rvalid1), 32'(tbl[k].v1));
      chk($sformatf("tbl%0d_rdata0", k), 32'(rdata0), 32'(tbl[k].q0));
      chk($sformatf("tbl%0d_rdata1", k), 32'(rdata1), 32'(tbl[k].q1));
      if (tbl[k].g0) begin
        mdl_last = 1'b0;
        if (tbl[k].w0) mdl_mem[tbl[k].a0] = tbl[k].d0;
      end
      if (tbl[k].g1) begin
        mdl_last = 1'b1;
        if (tbl[k].w1) mdl_mem[tbl[k].a1] = tbl[k].d1;
      end
    end
    exp_q[0] = tbl[9].q0;
    exp_q[1] = tbl[9].q1;

    // Randomized traffic against the reference model
    act[0] = 1'b0; act[1] = 1'b0;
    rwe[0] = 1'b0; rwe[1] = 1'b0;
    rad[0] = 6'd0; rad[1] = 6'd0;
    rwd[0] = 8'h00; rwd[1] = 8'h00;
    pend = 1'b0; pid = 1'b0; pdata = 8'h00;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!act[i] && n < 396 && $urandom_range(0, 99) < 65) begin
          act[i] = 1'b1;
          rwe[i] = ($urandom_range(0, 2) == 0);
          rad[i] = 6'($urandom_range(32, 39));
          rwd[i] = 8'($urandom);
        end
      end
      req0 = act[0]; we0 = rwe[0]; addr0 = rad[0]; wdata0 = rwd[0];
      req1 = act[1]; we1 = rwe[1]; addr1 = rad[1]; wdata1 = rwd[1];
      // Winner: a lone requester, or on a tie the one that did not win last
      eg[0] = act[0] && (!act[1] || mdl_last == 1'b1);
      eg[1] = act[1] && (!act[0] || mdl_last == 1'b0);
      #1;
      chk("rnd_gnt0", 32'(gnt0), 32'(eg[0]));
      chk("rnd_gnt1", 32'(gnt1), 32'(eg[1]));
      @(posedge clk);
      #1;
      if (pend) exp_q[pid] = pdata;
      chk("rnd_rvalid0", 32'(rvalid0), 32'(pend && pid == 1'b0));
      chk("rnd_rvalid1", 32'(rvalid1), 32'(pend && pid == 1'b1));
      chk("rnd_rdata0", 32'(rdata0), 32'(exp_q[0]));
      chk("rnd_rdata1", 32'(rdata1), 32'(exp_q[1]));
      pend = 1'b0;
      if (eg[0] || eg[1]) begin
        w = eg[1] ? 1 : 0;
        chk("rnd_mem_rw", 32'(mem_rw), 32'(rwe[w]));
        chk("rnd_mem_addr", 32'(mem_addr), 32'(rad[w]));
        if (rwe[w]) begin
          chk("rnd_mem_din", 32'(mem_din), 32'(rwd[w]));
          mdl_mem[rad[w]] = rwd[w];
        end else begin
          pend  = 1'b1;
          pid   = w[0];
          pdata = mdl_mem[rad[w]];
        end
        mdl_last = w[0];
        act[w] = 1'b0;
      end else begin
        chk("rnd_mem_rw_idle", 32'(mem_rw), 32'd0);
      end
    end

    // Reset pulsed while a read is in flight
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd35;
    req1 = 1'b0; we1 = 1'b0; addr1 = 6'd39;
    #1;
    chk("mid_gnt0", 32'(gnt0), 32'd1);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_gnt0", 32'(gnt0), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("mid_tie_gnt0", 32'(gnt0), 32'd1);
    chk("mid_tie_gnt1", 32'(gnt1), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_dropped_rvalid0", 32'(rvalid0), 32'd0);
    chk("mid_dropped_rvalid1", 32'(rvalid1), 32'd0);
    chk("mid_rdata0_clr", 32'(rdata0), 32'd0);
    chk("mid_rdata1_clr", 32'(rdata1), 32'd0);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    chk("mid_gnt1", 32'(gnt1), 32'd1);
    @(posedge clk);
    #1;
    chk("mid_rvalid0", 32'(rvalid0), 32'd1);
    chk("mid_rdata0", 32'(rdata0), 32'(mdl_mem[35]));
    @(negedge clk);
    req1 = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rvalid1", 32'(rvalid1), 32'd1);
    chk("mid_rdata1", 32'(rdata1), 32'(mdl_mem[39]));

    // Fixed priority: requester 0 always wins a tie
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      p_req0 = 1'b1; p_we0 = 1'b0; p_addr0 = 6'd39;
      p_req1 = 1'b1; p_we1 = 1'b0; p_addr1 = 6'd0;
      #1;
      chk($sformatf("prio%0d_gnt0", c), 32'(p_gnt0), 32'd1);
      chk($sformatf("prio%0d_gnt1", c), 32'(p_gnt1), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("prio%0d_rvalid0", c), 32'(p_rvalid0), 32'(c != 0));
      chk($sformatf("prio%0d_rvalid1", c), 32'(p_rvalid1), 32'd0);
      if (c != 0) chk($sformatf("prio%0d_rdata0", c), 32'(p_rdata0), 32'(init_val(39)));
    end
    @(negedge clk);
    p_req0 = 1'b0;
    #1;
    chk("prio_drop_gnt1", 32'(p_gnt1), 32'd1);
    chk("prio_drop_gnt0", 32'(p_gnt0), 32'd0);
    @(posedge clk);
    #1;
    chk("prio_last_rvalid0", 32'(p_rvalid0), 32'd1);
    @(negedge clk);
    p_req1 = 1'b0;
    @(posedge clk);
    #1;
    chk("prio_rvalid1", 32'(p_rvalid1), 32'd1);
    chk("prio_rdata1", 32'(p_rdata1), 32'(init_val(0)));
    chk("prio_rvalid0_off", 32'(p_rvalid0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
